// File: rtl/spi_slave_port_if.sv
// Pin-side and byte-stream signals of spi_slave_port, bundled for port use.
// The slave modport is the endpoint's view; the master modport drives it.
interface spi_slave_port_if;
   logic       spi_clk_i;
   logic       spi_mosi_i;
   logic [1:0] spi_nss_i;
   logic       spi_miso_o;
   logic       spi_miso_oe_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready_i;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic       rx_ovr_o;
   logic       frame_err_o;
   logic       clr_i;
   logic       busy_o;

   modport slave (
      input  spi_clk_i, spi_mosi_i, spi_nss_i, rx_ready_i, tx_data_i, tx_valid_i, clr_i,
      output spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
             rx_ovr_o, frame_err_o, busy_o
   );

   modport master (
      output spi_clk_i, spi_mosi_i, spi_nss_i, rx_ready_i, tx_data_i, tx_valid_i, clr_i,
      input  spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
             rx_ovr_o, frame_err_o, busy_o
   );
endinterface

// File: rtl/spi_slave_port.sv
// Oversampled byte-oriented SPI slave: MOSI -> rx valid/ready, tx holding -> MISO.
// Define SPI_SLAVE_ECHO_EN to refill an empty transmit slot with the last received byte.
module spi_slave_port #(
   parameter bit       CPOL     = 1'b0,
   parameter bit       CPHA     = 1'b0,
   parameter bit [0:0] CS_INDEX = 1'b0
) (
   input  logic            hclk,
   input  logic            hreset,
   spi_slave_port_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t     state;
   logic       clk_s1, clk_s2, clk_h;
   logic       mosi_s1, mosi_s2;
   logic       nss_s1, nss_s2, nss_h;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [6:0] tx_shift;
   logic       pend_load;
   logic       hold_full;
   logic [7:0] hold_data;
   logic       miso, miso_oe, busy, rx_valid, tx_ready, rx_ovr, frame_err;
   logic [7:0] rx_data;

   logic       lead, trail, sample_edge, shift_edge, nss_fall, nss_rise;
   logic       load, accept, hold_full_nx;
   logic [7:0] fill, load_src;

   assign lead     = (clk_h == CPOL) && (clk_s2 != CPOL);
   assign trail    = (clk_h != CPOL) && (clk_s2 == CPOL);
   assign nss_fall = nss_h & ~nss_s2;
   assign nss_rise = ~nss_h & nss_s2;

   // A select rise outranks any clock edge seen in the same cycle.
   assign sample_edge = (state == SHIFT) && !nss_rise && (CPHA ? trail : lead);
   assign shift_edge  = (state == SHIFT) && !nss_rise && (CPHA ? lead : trail);
   assign load        = ((state == LOAD) && !nss_rise) || (shift_edge && pend_load);
   assign accept      = bus.tx_valid_i && tx_ready;

`ifdef SPI_SLAVE_ECHO_EN
   assign fill = rx_data;
`else
   assign fill = 8'hFF;
`endif
   assign load_src = hold_full ? hold_data : fill;

   // An accept can only land on an empty slot, so a coincident load takes the fill.
   always_comb begin
      hold_full_nx = hold_full;
      if (accept)    hold_full_nx = 1'b1;
      else if (load) hold_full_nx = 1'b0;
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state     <= IDLE;
         clk_s1    <= CPOL;
         clk_s2    <= CPOL;
         clk_h     <= CPOL;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
         nss_s1    <= 1'b1;
         nss_s2    <= 1'b1;
         nss_h     <= 1'b1;
         bit_cnt   <= 3'd0;
         rx_shift  <= 7'd0;
         tx_shift  <= 7'h7F;
         pend_load <= 1'b0;
         hold_full <= 1'b0;
         hold_data <= 8'd0;
         miso      <= 1'b1;
         miso_oe   <= 1'b0;
         busy      <= 1'b0;
         rx_data   <= 8'd0;
         rx_valid  <= 1'b0;
         tx_ready  <= 1'b0;
         rx_ovr    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         clk_s1  <= bus.spi_clk_i;
         clk_s2  <= clk_s1;
         clk_h   <= clk_s2;
         mosi_s1 <= bus.spi_mosi_i;
         mosi_s2 <= mosi_s1;
         nss_s1  <= bus.spi_nss_i[CS_INDEX];
         nss_s2  <= nss_s1;
         nss_h   <= nss_s2;

         hold_full <= hold_full_nx;
         tx_ready  <= ~hold_full_nx;
         if (accept) hold_data <= bus.tx_data_i;

         // Clears come first so a same-cycle set below wins.
         if (bus.clr_i) begin
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
         end
         if (rx_valid && bus.rx_ready_i) rx_valid <= 1'b0;

         if (nss_rise && state != IDLE) begin
            if (state == SHIFT && bit_cnt != 3'd0) frame_err <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            pend_load <= 1'b0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  bit_cnt   <= 3'd0;
                  pend_load <= 1'b0;
                  miso      <= 1'b1;
                  if (nss_fall) begin
                     state   <= LOAD;
                     miso_oe <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
               LOAD: begin
                  tx_shift <= load_src[6:0];
                  miso     <= load_src[7];
                  state    <= SHIFT;
               end
               SHIFT: begin
                  if (sample_edge) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_data   <= {rx_shift, mosi_s2};
                        rx_valid  <= 1'b1;
                        pend_load <= 1'b1;
                        if (rx_valid && !bus.rx_ready_i) rx_ovr <= 1'b1;
                     end else begin
                        rx_shift <= {rx_shift[5:0], mosi_s2};
                     end
                  end
                  // CPHA=1: the first leading edge of a frame carries the MSB already on MISO.
                  if (shift_edge) begin
                     if (pend_load) begin
                        tx_shift  <= load_src[6:0];
                        miso      <= load_src[7];
                        pend_load <= 1'b0;
                     end else if (!(CPHA && bit_cnt == 3'd0)) begin
                        tx_shift <= {tx_shift[5:0], 1'b1};
                        miso     <= tx_shift[6];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.spi_miso_o    = miso;
   assign bus.spi_miso_oe_o = miso_oe;
   assign bus.busy_o        = busy;
   assign bus.rx_data_o     = rx_data;
   assign bus.rx_valid_o    = rx_valid;
   assign bus.tx_ready_o    = tx_ready;
   assign bus.rx_ovr_o      = rx_ovr;
   assign bus.frame_err_o   = frame_err;
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: three instances share one SPI bus
// (mode 0 on CS0, mode 1 on CS0, mode 0 on CS1 which is never selected).
module tb_spi_slave_port;
   logic             hclk = 1'b0;
   logic             hreset = 1'b1;
   logic             sclk = 1'b0, mosi = 1'b0;
   logic [1:0]       nss = 2'b11;
   logic [2:0]       miso, oe, rxv, txr, ovr, ferr, busy;
   logic [2:0]       rdy = 3'b110, txv = 3'b000, clr = 3'b000;
   logic [2:0][7:0]  rxd;
   logic [2:0][7:0]  txd = '0;
   logic [14:0]      outs0;
   logic [7:0]       rxq1 [$];
   bit               seen2 = 1'b0;
   int               checks = 0, failures = 0;

   always #5 hclk = ~hclk;

   for (genvar g = 0; g < 3; g++) begin : u
      spi_slave_port_if b ();
      spi_slave_port #(.CPOL(1'b0), .CPHA(g == 1), .CS_INDEX(g == 2)) dut (
         .hclk(hclk), .hreset(hreset), .bus(b.slave));
      assign b.spi_clk_i  = sclk;
      assign b.spi_mosi_i = mosi;
      assign b.spi_nss_i  = nss;
      assign b.rx_ready_i = rdy[g];
      assign b.tx_data_i  = txd[g];
      assign b.tx_valid_i = txv[g];
      assign b.clr_i      = clr[g];
      assign miso[g] = b.spi_miso_o;
      assign oe[g]   = b.spi_miso_oe_o;
      assign rxd[g]  = b.rx_data_o;
      assign rxv[g]  = b.rx_valid_o;
      assign txr[g]  = b.tx_ready_o;
      assign ovr[g]  = b.rx_ovr_o;
      assign ferr[g] = b.frame_err_o;
      assign busy[g] = b.busy_o;
   end

   assign outs0 = {miso[0], oe[0], rxd[0], rxv[0], txr[0], ovr[0], ferr[0], busy[0]};

   always @(negedge hclk) begin
      if (rxv[1] && rdy[1]) rxq1.push_back(rxd[1]);
      if (rxv[2] || busy[2] || oe[2]) seen2 = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(negedge hclk);
   endtask

   task automatic tx_push(input int i, input logic [7:0] d);
      int n;
      n = 0;
      while (!txr[i] && n < 500) begin
         wt(1);
         n++;
      end
      if (n >= 500) chk("tx_ready_timeout", txr[i], 1);
      txd[i] = d;
      txv[i] = 1'b1;
      wt(1);
      txv[i] = 1'b0;
   endtask

   // Master model, CPOL=0. Byte k of mo/mi sits in bits [8k+7:8k], MSB first on the wire.
   task automatic frame(input int cpha, input int div, input int nbits,
                        input logic [31:0] mo, input bit clr_last, output logic [31:0] mi);
      int p;
      mi  = '0;
      nss = 2'b10;
      wt(2 * div);
      for (int j = 0; j < nbits; j++) begin
         p = 8 * (j / 8) + 7 - (j % 8);
         if (cpha == 0) begin
            mosi = mo[p];
            wt(div);
            mi[p] = miso[0];
            sclk  = 1'b1;
            if (clr_last && j == nbits - 1) begin
               wt(2);
               clr[0] = 1'b1;
               wt(1);
               clr[0] = 1'b0;
               wt(div - 3);
            end else begin
               wt(div);
            end
            sclk = 1'b0;
         end else begin
            sclk = 1'b1;
            mosi = mo[p];
            wt(div);
            mi[p] = miso[1];
            sclk  = 1'b0;
            wt(div);
         end
      end
      wt(div);
      nss = 2'b11;
      wt(8);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] mi;
      logic [15:0] q;

      wt(3);
      chk("rst_outs", outs0, 15'h4000);
      chk("rst_d1_miso", miso[1], 1);
      hreset = 1'b0;
      wt(1);
      chk("txr_post_rst", txr[0], 1);

      // mode 0, div 4
      tx_push(0, 8'h3C);
      chk("t1_txr_drop", txr[0], 0);
      frame(0, 4, 8, 32'hA5, 1'b0, mi);
      chk("t1_miso", mi[7:0], 8'h3C);
      chk("t1_txr_rise", txr[0], 1);
      chk("t1_rx", {rxv[0], rxd[0]}, 9'h1A5);
      wt(10);
      chk("t1_rx_held", rxv[0], 1);
      rdy[0] = 1'b1;
      wt(1);
      rdy[0] = 1'b0;
      chk("t1_rx_consumed", rxv[0], 0);

      // mode 1, back-to-back, div 7
      clr = 3'b111;
      wt(1);
      clr = 3'b000;
      rxq1.delete();
      tx_push(1, 8'h81);
      fork
         frame(1, 7, 16, 32'h3412, 1'b0, mi);
         tx_push(1, 8'h7E);
      join
      chk("t2_miso", mi[15:0], 16'h7E81);
      chk("t2_rx_cnt", rxq1.size(), 2);
      q = (rxq1.size() == 2) ? {rxq1[0], rxq1[1]} : 16'hDEAD;
      chk("t2_rx", q, 16'h1234);
      chk("t2_ferr", ferr[1], 0);
      chk("t2_txr", txr[1], 1);

      // empty holding, mode 0, div 7
      hreset = 1'b1;
      wt(3);
      hreset = 1'b0;
      wt(2);
      rdy[0] = 1'b1;
      frame(0, 7, 16, 32'h6655, 1'b0, mi);
`ifdef SPI_SLAVE_ECHO_EN
      chk("t3_miso", mi[15:0], 16'h5500);
`else
      chk("t3_miso", mi[15:0], 16'hFFFF);
`endif
      chk("t3_rxd", rxd[0], 8'h66);

      // overrun
      rdy[0] = 1'b0;
      frame(0, 4, 16, 32'h0201, 1'b0, mi);
      chk("t4_rx", {rxv[0], rxd[0]}, 9'h102);
      chk("t4_ovr", ovr[0], 1);
      clr[0] = 1'b1;
      wt(1);
      clr[0] = 1'b0;
      chk("t4_ovr_clr", ovr[0], 0);
      frame(0, 4, 8, 32'h03, 1'b1, mi);
      chk("t4_ovr_coinc", ovr[0], 1);
      chk("t4_rxd3", rxd[0], 8'h03);

      // abort after 3 bits, byte queued mid-frame survives
      rdy[0] = 1'b1;
      clr = 3'b111;
      wt(2);
      clr = 3'b000;
      rdy[0] = 1'b0;
      fork
         frame(0, 4, 3, 32'hE0, 1'b0, mi);
         begin
            wt(12);
            tx_push(0, 8'hC3);
         end
      join
      chk("t5_ferr", ferr[0], 1);
      chk("t5_no_rx", rxv[0], 0);
      chk("t5_hold_kept", txr[0], 0);
      frame(0, 4, 8, 32'h5A, 1'b0, mi);
      chk("t5_miso", mi[7:0], 8'hC3);
      chk("t5_rx", {rxv[0], rxd[0]}, 9'h15A);

      // select isolation on CS1, then reset mid-byte
      fork
         frame(0, 4, 8, 32'hAA, 1'b0, mi);
         begin
            wt(30);
            chk("t6_iso", {busy[2], oe[2]}, 0);
            chk("t6_sel0_busy", busy[0], 1);
         end
      join
      chk("t6_no_rx2", seen2, 0);
      fork
         frame(0, 4, 8, 32'hAA, 1'b0, mi);
         begin
            wt(30);
            hreset = 1'b1;
            wt(2);
            chk("t6_rst_mid", outs0, 15'h4000);
         end
      join
      wt(2);
      hreset = 1'b0;
      wt(3);
      chk("t6_post_rst", {ferr[0], busy[0], rxv[0], ovr[0]}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
